// File: rtl/pipe_pkg.sv
// Purpose: shared constants and types for the CPU pipeline-stage registers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pipe_pkg;

    // Channel positions inside a stage register word.
    localparam int CH_IR  = 0;
    localparam int CH_AO  = 1;
    localparam int CH_DR  = 2;
    localparam int CH_PC  = 3;
    localparam int CH_PC4 = 4;

    // Default geometry of a stage register.
    localparam int DEF_W      = 32;
    localparam int DEF_CH     = 5;
    localparam int DEF_PC_IDX = CH_PC;

    // Per-cycle command applied to one storage slot.
    typedef enum logic [1:0] {
        SLOT_HOLD  = 2'd0,  // keep valid and data
        SLOT_LOAD  = 2'd1,  // take new data, mark valid
        SLOT_CLEAR = 2'd2,  // drop valid, keep data visible
        SLOT_FLUSH = 2'd3   // drop valid, replace data with the flush word
    } slot_op_e;

endpackage

// File: rtl/pipe_slot.sv
// Purpose: one CH*W data register plus valid bit, driven by a slot_op_e command.
// Latency: 1 cycle from command to updated valid/data.
// Backpressure: none internally; the owner decides when to load or clear.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int CH      = DEF_CH,
    parameter int PC_IDX  = DEF_PC_IDX,
    parameter bit KEEP_PC = 1'b1
)(
    input  logic            clk,
    input  logic            reset,
    input  slot_op_e        op,
    input  logic [CH*W-1:0] load_data,
    input  logic [W-1:0]    flush_pc,
    output logic            valid,
    output logic [CH*W-1:0] data
);

    logic [CH*W-1:0] flush_word;

    // Flush word: all-zero, with the PC channel preserved only in the main slot.
    always_comb begin
        flush_word = '0;
        if (KEEP_PC) begin
            flush_word[PC_IDX*W +: W] = flush_pc;
        end
    end

    // Slot state update; reset beats every command.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            case (op)
                SLOT_LOAD: begin
                    valid <= 1'b1;
                    data  <= load_data;
                end
                SLOT_CLEAR: begin
                    valid <= 1'b0;
                end
                SLOT_FLUSH: begin
                    valid <= 1'b0;
                    data  <= flush_word;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Purpose: parametrised CPU pipeline-stage register with valid/ready, flush-to-bubble and optional skid slot.
// Latency: 1 cycle accept-to-out_valid; a beat parked in the skid slot waits one extra cycle per stall cycle.
// Backpressure: SKID=0 in_ready = !out_valid || out_ready (combinational); SKID=1 in_ready = !skid_valid (registered).
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int CH     = DEF_CH,
    parameter int PC_IDX = DEF_PC_IDX,
    parameter bit SKID   = 1'b0
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic [W-1:0]    flush_pc,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CH*W-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CH*W-1:0] out_data
);

    if (PC_IDX < 0 || PC_IDX >= CH) begin : g_bad_pc_idx
        $error("pipe_stage_reg: PC_IDX must lie in [0, CH)");
    end

    logic            main_valid;
    logic [CH*W-1:0] main_data;
    logic [CH*W-1:0] main_load;
    slot_op_e        main_op;
    logic            accept;

    assign accept    = in_valid && in_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;

    pipe_slot #(
        .W       (W),
        .CH      (CH),
        .PC_IDX  (PC_IDX),
        .KEEP_PC (1'b1)
    ) u_main (
        .clk       (clk),
        .reset     (reset),
        .op        (main_op),
        .load_data (main_load),
        .flush_pc  (flush_pc),
        .valid     (main_valid),
        .data      (main_data)
    );

    if (SKID) begin : g_skid
        logic            skid_valid;
        logic [CH*W-1:0] skid_data;
        slot_op_e        skid_op;
        logic            main_free;

        // Main slot can take a beat this cycle if empty or draining downstream.
        assign main_free = !main_valid || out_ready;
        // Registered-only ready: the skid slot absorbs the beat accepted while stalling.
        assign in_ready  = !skid_valid;

        pipe_slot #(
            .W       (W),
            .CH      (CH),
            .PC_IDX  (PC_IDX),
            .KEEP_PC (1'b0)
        ) u_skid (
            .clk       (clk),
            .reset     (reset),
            .op        (skid_op),
            .load_data (in_data),
            .flush_pc  (flush_pc),
            .valid     (skid_valid),
            .data      (skid_data)
        );

        // Steer beats: flush kills both slots; the skid beat always moves ahead of a new one.
        always_comb begin
            main_op   = SLOT_HOLD;
            main_load = in_data;
            skid_op   = SLOT_HOLD;
            if (flush) begin
                main_op = SLOT_FLUSH;
                skid_op = SLOT_FLUSH;
            end else if (main_free) begin
                if (skid_valid) begin
                    main_op   = SLOT_LOAD;
                    main_load = skid_data;
                    skid_op   = SLOT_CLEAR;
                end else if (accept) begin
                    main_op = SLOT_LOAD;
                end else begin
                    main_op = SLOT_CLEAR;
                end
            end else if (accept) begin
                skid_op = SLOT_LOAD;
            end
        end

        // The skid slot only ever fills behind a live main beat.
        a_skid_behind_main: assert property (@(posedge clk) disable iff (reset)
            skid_valid |-> main_valid);
    end else begin : g_single
        // Combinational ready: a draining slot can be refilled in the same cycle.
        assign in_ready = !main_valid || out_ready;

        // Single-slot control: flush, then load on accept, else drop valid on emit.
        always_comb begin
            main_op   = SLOT_HOLD;
            main_load = in_data;
            if (flush) begin
                main_op = SLOT_FLUSH;
            end else if (accept) begin
                main_op = SLOT_LOAD;
            end else if (main_valid && out_ready) begin
                main_op = SLOT_CLEAR;
            end
        end
    end

    // A stalled beat must stay put and stay valid.
    a_stall_hold: assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Purpose: scoreboard bench for pipe_stage_reg in three configurations driven by shared control stimulus.
// Latency: model expects a beat one cycle after accept, plus any skid wait.
// Backpressure: random out_ready stalls; in_ready checked against slot occupancy.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int NCFG = 3;
    localparam int NCYC = 400;
    localparam int DW   = 160;

    function automatic int cfg_w(int g);    return (g == 2) ? 16 : 32;     endfunction
    function automatic int cfg_ch(int g);   return (g == 2) ? 3 : 5;       endfunction
    function automatic int cfg_pc(int g);   return (g == 2) ? 0 : CH_PC;   endfunction
    function automatic bit cfg_skid(int g); return (g == 0) ? 1'b0 : 1'b1; endfunction

    function automatic logic [DW-1:0] full_mask(int g);
        logic [DW-1:0] m;
        m = '1;
        return ~(m << (cfg_w(g) * cfg_ch(g)));
    endfunction

    // Replace channel k of word d with v (truncated to the channel width).
    function automatic logic [DW-1:0] put_ch(logic [DW-1:0] d, int g, int k, logic [31:0] v);
        logic [DW-1:0] m;
        logic [DW-1:0] val;
        m   = (cfg_w(g) == 16) ? DW'(32'h0000_FFFF) : DW'(32'hFFFF_FFFF);
        val = DW'(v) & m;
        return (d & ~(m << (k * cfg_w(g)))) | (val << (k * cfg_w(g)));
    endfunction

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic [31:0]   flush_pc;
    logic          in_valid;
    logic          out_ready;
    logic [DW-1:0] in_data  [NCFG];
    logic [DW-1:0] out_data [NCFG];
    logic          in_ready [NCFG];
    logic          out_valid[NCFG];

    logic [DW-1:0] q[NCFG][$];
    logic [DW-1:0] hold[NCFG];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    bit            mon_on   = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        localparam int WG  = cfg_w(g);
        localparam int CHG = cfg_ch(g);
        logic [CHG*WG-1:0] dout;
        logic              rdy;
        logic              vld;

        pipe_stage_reg #(
            .W      (WG),
            .CH     (CHG),
            .PC_IDX (cfg_pc(g)),
            .SKID   (cfg_skid(g))
        ) dut (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .flush_pc  (flush_pc[WG-1:0]),
            .in_valid  (in_valid),
            .in_ready  (rdy),
            .in_data   (in_data[g][CHG*WG-1:0]),
            .out_valid (vld),
            .out_ready (out_ready),
            .out_data  (dout)
        );

        assign out_data[g]  = DW'(dout);
        assign in_ready[g]  = rdy;
        assign out_valid[g] = vld;
    end

    task automatic chk(string name, int g, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cfg%0d cycle %0d: got %h expected %h", name, g, cyc, act, exp);
        end
    endtask

    // Monitor: compare what each DUT presents against the scoreboard, pop on emit.
    always @(negedge clk) begin
        #2;
        if (mon_on) begin
            for (int g = 0; g < NCFG; g++) begin
                int            occ;
                bit            exp_v;
                bit            exp_r;
                logic [DW-1:0] exp_d;
                occ   = q[g].size();
                exp_v = (occ > 0);
                exp_d = exp_v ? q[g][0] : hold[g];
                exp_r = cfg_skid(g) ? (occ < 2) : (occ == 0 || out_ready);
                chk("out_valid", g, DW'(out_valid[g]), DW'(exp_v));
                chk("in_ready",  g, DW'(in_ready[g]),  DW'(exp_r));
                chk("out_data",  g, out_data[g], exp_d);
                if (exp_v && out_ready) begin
                    hold[g] = q[g].pop_front();
                end
            end
        end
    end

    // Stimulus: directed prologue then random traffic; accepted beats go to the scoreboard.
    initial begin
        bit            rs;
        bit            fl;
        bit            iv;
        bit            ordy;
        logic [DW-1:0] d;

        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        flush_pc  = '0;
        for (int g = 0; g < NCFG; g++) begin
            in_data[g] = '0;
            hold[g]    = '0;
        end
        @(posedge clk);
        mon_on = 1'b1;

        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            cyc  = c;
            rs   = ($urandom_range(0, 199) == 0);
            fl   = ($urandom_range(0, 19) == 0);
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 6);
            if (c < 2)                 begin rs = 1; fl = 0; iv = 1; ordy = 0; end
            else if (c < 10)           begin rs = 0; fl = 0; iv = 1; ordy = 1; end
            else if (c < 14)           begin rs = 0; fl = 0; iv = 1; ordy = 0; end
            else if (c < 17)           begin rs = 0; fl = 0; iv = 0; ordy = 1; end
            else if (c == 17)          begin rs = 0; fl = 0; iv = 1; ordy = 0; end
            else if (c == 18)          begin rs = 0; fl = 1; iv = 1; ordy = 0; end
            else if (c == 19)          begin rs = 0; fl = 0; iv = 0; ordy = 1; end
            else if (c == 20)          begin rs = 0; fl = 0; iv = 1; ordy = 0; end
            else if (c == 21)          begin rs = 1; fl = 1; iv = 1; ordy = 0; end
            if (fl) ordy = 0;

            flush_pc = (c == 18 || c == 21) ? 32'h0000_3010 : $urandom;
            for (int g = 0; g < NCFG; g++) begin
                d = {$urandom, $urandom, $urandom, $urandom, $urandom};
                if (c == 2) begin
                    d = put_ch(d, g, CH_IR, 32'h8C08_0004);
                    d = put_ch(d, g, cfg_pc(g), 32'h0000_3000);
                end
                in_data[g] = d & full_mask(g);
            end
            reset     = rs;
            flush     = fl;
            in_valid  = iv;
            out_ready = ordy;

            #3;
            for (int g = 0; g < NCFG; g++) begin
                if (reset) begin
                    q[g].delete();
                    hold[g] = '0;
                end else if (flush) begin
                    q[g].delete();
                    hold[g] = put_ch('0, g, cfg_pc(g), flush_pc);
                end else if (in_valid && in_ready[g]) begin
                    q[g].push_back(in_data[g]);
                end
            end
        end

        @(negedge clk);
        #4;
        mon_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
